// File: rtl/gcd_controller_pkg.sv
// Shared types and constants for the GCD controller and its datapath.
package gcd_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      CALC   = 3'd3,
      DONE   = 3'd4
   } gcd_state_t;

   localparam logic SEL_A    = 1'b0;
   localparam logic SEL_B    = 1'b1;
   localparam logic BUS_DATA = 1'b1;
   localparam logic BUS_SUB  = 1'b0;

   localparam int DATA_W = 16;

endpackage

// File: rtl/gcd_controller_if.sv
// Host and datapath signals of the GCD controller, grouped as one bundle.
interface gcd_controller_if #(
   parameter int CNT_W = 16
);
   // Operand transfer happens on a rising clk edge where in_valid && in_ready;
   // the result transfer happens on an edge where done && out_ready. Neither
   // side may make its signal depend on the other within the same cycle
   // except in_ready, which is combinational from controller state only.
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic             gt;
   logic             lt;
   logic             eq;
   logic             ldA;
   logic             ldB;
   logic             sel1;
   logic             sel2;
   logic             sel_in;
   logic             busy;
   logic             done;
   logic             out_ready;
   logic             err;
   logic [CNT_W-1:0] iter_count;

   modport master (
      output start, in_valid, gt, lt, eq, out_ready,
      input  in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
   );

   modport slave (
      input  start, in_valid, gt, lt, eq, out_ready,
      output in_ready, ldA, ldB, sel1, sel2, sel_in, busy, done, err, iter_count
   );

endinterface

// File: rtl/gcd_controller_iter_counter.sv
// Saturating subtraction counter with synchronous clear and terminal compare.
module gcd_iter_counter #(
   parameter int MAX   = 65535,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             at_max
);

   assign at_max = (count == WIDTH'(MAX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-compare GCD datapath: loads two operands,
// iterates on the compare flags, and holds the result until the host takes it.
module gcd_controller
   import gcd_pkg::*;
#(
   parameter int MAX_ITER = 65535,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   gcd_controller_if.slave  bus,
   output gcd_state_t       fsm_state
);

   gcd_state_t state;
   logic       done_q;
   logic       err_q;
   logic       busy_q;

   logic in_ready_c, ld_a_c, ld_b_c, sel1_c, sel2_c, sel_in_c;
   logic cnt_clr, cnt_inc, at_max;

   gcd_iter_counter #(
      .MAX   (MAX_ITER),
      .WIDTH (CNT_W)
   ) u_iter_counter (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .count  (bus.iter_count),
      .at_max (at_max)
   );

   // Load enables and selects are decoded straight from state and flags so a
   // subtraction lands on the same edge CALC sees the flags.
   always_comb begin
      in_ready_c = 1'b0;
      ld_a_c     = 1'b0;
      ld_b_c     = 1'b0;
      sel1_c     = SEL_A;
      sel2_c     = SEL_A;
      sel_in_c   = BUS_SUB;
      cnt_inc    = 1'b0;
      cnt_clr    = (state == IDLE) && bus.start;
      case (state)
         LOAD_A: begin
            in_ready_c = 1'b1;
            sel_in_c   = BUS_DATA;
            ld_a_c     = bus.in_valid;
         end
         LOAD_B: begin
            in_ready_c = 1'b1;
            sel_in_c   = BUS_DATA;
            ld_b_c     = bus.in_valid;
         end
         CALC: begin
            if (!bus.eq && !at_max) begin
               if (bus.lt) begin
                  sel1_c  = SEL_B;
                  sel2_c  = SEL_A;
                  ld_b_c  = 1'b1;
                  cnt_inc = 1'b1;
               end else if (bus.gt) begin
                  sel1_c  = SEL_A;
                  sel2_c  = SEL_B;
                  ld_a_c  = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= LOAD_A;
                  busy_q <= 1'b1;
                  err_q  <= 1'b0;
               end
            end
            LOAD_A: begin
               if (bus.in_valid) state <= LOAD_B;
            end
            LOAD_B: begin
               if (bus.in_valid) state <= CALC;
            end
            CALC: begin
               if (bus.eq) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else if (at_max || !(bus.lt || bus.gt)) begin
                  // Budget exhausted (e.g. a zero operand) or inconsistent flags.
                  state  <= DONE;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state  <= IDLE;
                  done_q <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.ldA      = ld_a_c;
   assign bus.ldB      = ld_b_c;
   assign bus.sel1     = sel1_c;
   assign bus.sel2     = sel2_c;
   assign bus.sel_in   = sel_in_c;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.busy     = busy_q;
   assign fsm_state    = state;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: a behavioural datapath closes the loop and a
// Euclid-by-subtraction reference predicts result, counts and latency.
module tb_gcd_controller;
   import gcd_pkg::*;

   localparam int MAX   = 16;
   localparam int CW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   gcd_state_t fsm_state;

   gcd_controller_if #(.CNT_W(CW)) ifc ();

   gcd_controller #(
      .MAX_ITER (MAX),
      .CNT_W    (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc.slave),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   // Datapath stand-in: two registers, subtractor, bus mux, compare flags.
   logic [DATA_W-1:0] a_reg = '0;
   logic [DATA_W-1:0] b_reg = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic [DATA_W-1:0] sub_val, bus_val;

   assign sub_val = (ifc.sel1 ? b_reg : a_reg) - (ifc.sel2 ? b_reg : a_reg);
   assign bus_val = ifc.sel_in ? data_in : sub_val;
   assign ifc.gt  = (a_reg > b_reg);
   assign ifc.lt  = (a_reg < b_reg);
   assign ifc.eq  = (a_reg == b_reg);

   always @(posedge clk) begin
      if (ifc.ldA) a_reg <= bus_val;
      if (ifc.ldB) b_reg <= bus_val;
   end

   int cyc = 0;
   int n_lda = 0;
   int n_ldb = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ifc.ldA) n_lda <= n_lda + 1;
      if (ifc.ldB) n_ldb <= n_ldb + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: repeated subtraction of the smaller from the larger, with the
   // subtraction budget applied before each step.
   task automatic ref_gcd(input int x_in, input int y_in,
                          output int res, output int na, output int nb, output int e);
      int x, y;
      x = x_in; y = y_in; na = 0; nb = 0; e = 0;
      while (x != y) begin
         if (na + nb == MAX) begin
            e = 1;
            break;
         end
         if (x > y) begin x = x - y; na++; end
         else begin y = y - x; nb++; end
      end
      res = x;
   endtask

   task automatic send(input logic [DATA_W-1:0] v, input int stall);
      int k;
      for (int i = 0; i < stall; i++) begin
         ifc.in_valid = 1'b0;
         data_in = DATA_W'($urandom);
         @(negedge clk);
      end
      data_in = v;
      ifc.in_valid = 1'b1;
      k = 0;
      while (!ifc.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("in_ready_seen", ifc.in_ready, 1'b1);
      @(negedge clk);
      ifc.in_valid = 1'b0;
   endtask

   task automatic run(input int x, input int y, input int sa, input int sb, input int hold);
      int res, na, nb, e, t0, lda0, ldb0, w;
      ref_gcd(x, y, res, na, nb, e);
      ifc.out_ready = (hold == 0);
      @(negedge clk);
      ifc.start = 1'b1;
      t0 = cyc;
      lda0 = n_lda;
      ldb0 = n_ldb;
      @(negedge clk);
      ifc.start = 1'b0;
      chk("busy_after_start", ifc.busy, 1'b1);
      send(DATA_W'(x), sa);
      send(DATA_W'(y), sb);
      w = 0;
      while (!ifc.done && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("done_seen", ifc.done, 1'b1);
      chk("latency", cyc - t0, na + nb + 4 + sa + sb);
      chk("err", ifc.err, e[0]);
      chk("iter_count", ifc.iter_count, na + nb);
      chk("result_a", a_reg, res);
      chk("lda_pulses", n_lda - lda0, 1 + na);
      chk("ldb_pulses", n_ldb - ldb0, 1 + nb);
      for (int i = 0; i < hold; i++) begin
         chk("done_hold", ifc.done, 1'b1);
         ifc.start = (i == 3);
         @(negedge clk);
      end
      ifc.start = 1'b0;
      ifc.out_ready = 1'b1;
      @(negedge clk);
      chk("done_cleared", ifc.done, 1'b0);
      chk("idle_busy", ifc.busy, 1'b0);
      chk("idle_state", fsm_state, IDLE);
      chk("count_held", ifc.iter_count, na + nb);
      ifc.out_ready = 1'b0;
   endtask

   initial begin
      ifc.start     = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      #1;
      chk("rst_done", ifc.done, 1'b0);
      chk("rst_busy", ifc.busy, 1'b0);
      chk("rst_err", ifc.err, 1'b0);
      chk("rst_in_ready", ifc.in_ready, 1'b0);
      chk("rst_sel_in", ifc.sel_in, 1'b0);
      chk("rst_count", ifc.iter_count, 0);
      chk("rst_state", fsm_state, IDLE);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run(48, 18, 0, 0, 0);
      run(7, 7, 0, 0, 0);
      run(5, 0, 0, 0, 0);
      run(21, 14, 3, 2, 0);
      run(48, 18, 0, 0, 10);

      // Reset in the middle of a long run.
      @(negedge clk);
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      send(16'd1000, 0);
      send(16'd3, 0);
      repeat (4) @(negedge clk);
      chk("mid_calc_busy", ifc.busy, 1'b1);
      chk("mid_calc_lda", ifc.ldA, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_done", ifc.done, 1'b0);
      chk("arst_busy", ifc.busy, 1'b0);
      chk("arst_lda", ifc.ldA, 1'b0);
      chk("arst_ldb", ifc.ldB, 1'b0);
      chk("arst_sel2", ifc.sel2, 1'b0);
      chk("arst_sel_in", ifc.sel_in, 1'b0);
      chk("arst_count", ifc.iter_count, 0);
      chk("arst_state", fsm_state, IDLE);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no_done_after_rst", ifc.done, 1'b0);
      end
      run(9, 6, 0, 0, 0);

      for (int r = 0; r < 8; r++) begin
         run($urandom_range(1, 40), $urandom_range(0, 40),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
